oam_dma_ctrl: RTL and testbench
===============================

# oam_dma_ctrl

Sprite-DMA sequencer and system-bus arbiter between the CPU and the $4014 OAM transfer engine. A CPU write to $4014 latches a source page and halts the CPU through `cpu_rdy`. The block then owns the external address/data bus and copies 256 bytes from {page, 00..FF} to the PPU OAM data port $2004 using alternating read/write cycles. Control returns to the CPU afterwards. It sits between the CPU core's address/data outputs and the system bus decoder.

## Interface
Parameters:
- `DMA_REG`, 16'h4014: CPU write address that triggers a transfer.
- `OAM_PORT`, 16'h2004: destination address for every DMA write.

Ports:
- `clk_ph1`, in, 1: single system clock; all state updates on its rising edge.
- `rst`, in, 1: synchronous, active-low reset.
- `cpu_addr`, in, 16: CPU address bus.
- `cpu_dout`, in, 8: CPU write data.
- `cpu_we`, in, 1: CPU write strobe (1 = write cycle, 0 = read cycle).
- `bus_din`, in, 8: read data returned from the system bus.
- `bus_addr`, out, 16: arbitrated system address.
- `bus_dout`, out, 8: arbitrated write data.
- `bus_we`, out, 1: arbitrated write strobe.
- `cpu_rdy`, out, 1: 0 = CPU must stall (hold its current read cycle).
- `dma_busy`, out, 1: high in any non-IDLE state.

## Operation
- **States:** IDLE, HALT, ALIGN, READ, WRITE.
- **Registers:**
  - `page[7:0]`: source page.
  - `idx[7:0]`: byte index.
  - `data[7:0]`: transfer latch.
  - `odd`: cycle-parity bit. Reset 0, toggles every clock unconditionally, including during DMA.
- **IDLE:**
  - `cpu_rdy`=1.
  - Bus mux passes `cpu_addr`/`cpu_dout`/`cpu_we` through.
  - On `cpu_we`=1 with `cpu_addr`==`DMA_REG`: latch `page`<=`cpu_dout`, `idx`<=0, go to HALT.
- **HALT:**
  - `cpu_rdy`=0; bus still passes the CPU through.
  - If `cpu_we`=1, stay in HALT. The CPU cannot stall on a write; that write completes on the bus, including any further $4014 write, which is ignored.
  - If `cpu_we`=0: go to READ when `odd`=1 this cycle, otherwise go to ALIGN.
- **ALIGN:**
  - One dummy cycle: `bus_addr`=`cpu_addr`, `bus_we`=0, `cpu_rdy`=0.
  - Then go to READ.
- **READ** (always on an `odd`=0 cycle):
  - `bus_addr`={`page`,`idx`}, `bus_we`=0.
  - `data`<=`bus_din` at the end of the cycle; go to WRITE.
- **WRITE:**
  - `bus_addr`=`OAM_PORT`, `bus_dout`=`data`, `bus_we`=1.
  - If `idx`==FF: go to IDLE. Otherwise `idx`<=`idx`+1 and go to READ.
- **Wrap rule:** `idx` is 8-bit and the source address never carries into `page`. Page FF reads FF00..FFFF.
- **Mux outputs:** `bus_dout` is `cpu_dout` in IDLE/HALT/ALIGN. `bus_we` is forced 0 in ALIGN/READ.
- **Reset** (`rst`=0 at an edge, including mid-transfer):
  - state=IDLE, `idx`=0, `page`=0, `data`=0, `odd`=0.
  - Outputs: `cpu_rdy`=1, `dma_busy`=0.
  - Bus follows the CPU.
  - No partial transfer resumes.

## Timing
- The trigger write is sampled at edge E. `cpu_rdy` falls and `dma_busy` rises in the cycle after E; both are registered.
- **Stall length**, with the CPU reading in the first HALT cycle: 1 HALT + 0/1 ALIGN + 512 = 513 or 514 cycles of `cpu_rdy`=0. Each extra CPU write cycle in HALT adds 1.
- The first DMA read address appears 1 or 2 cycles after HALT begins. Read/write pairs are back-to-back with no gaps.
- `cpu_rdy` returns to 1 in the cycle after the last WRITE (`idx`=FF). `dma_busy` falls in the same cycle.
- Every READ cycle has `odd`=0 and every WRITE cycle has `odd`=1.
- Outputs in IDLE/HALT are combinational from the CPU inputs (zero latency). In DMA states they are driven from registers.

## Test plan
- **Basic transfer:**
  - Stimulus: reset, then CPU writes 8'h02 to $4014 with `odd`=1 at HALT; memory 0200..02FF = index value.
  - Expect: 256 writes to $2004 with data 00..FF in order, `cpu_rdy` low for exactly 513 cycles.
- **Alignment:**
  - Stimulus: same as basic transfer, but the trigger is shifted one cycle so HALT lands on `odd`=0.
  - Expect: one ALIGN cycle with `bus_we`=0 and a stall of 514 cycles; all READs on `odd`=0.
- **Write during HALT:**
  - Stimulus: CPU holds `cpu_we`=1 for 2 cycles after the trigger, one of them a write of 8'h05 to $4014.
  - Expect: both writes appear on the bus, transfer still sources page 02, stall 515/516 cycles.
- **Page FF wrap:**
  - Stimulus: write 8'hFF to $4014.
  - Expect: reads FF00..FFFF, last read address FFFF, no access to 0000.
- **Reset mid-transfer:**
  - Stimulus: assert `rst`=0 for one edge at `idx`=8'h40.
  - Expect: next cycle `cpu_rdy`=1, `dma_busy`=0, bus equals CPU inputs, no further $2004 writes.
- **Pass-through:**
  - Stimulus: in IDLE, CPU writes 8'hAA to $2004 and reads $0300.
  - Expect: bus mirrors the CPU exactly, `dma_busy` stays 0.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// Sprite-DMA sequencer: halts the CPU on a $4014 write, copies 256 bytes from
// {page,00..FF} to the OAM data port, then hands the system bus back to the CPU.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG  = 16'h4014,
  parameter logic [15:0] OAM_PORT = 16'h2004
) (
  input  logic        clk_ph1,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_we,
  input  logic [7:0]  bus_din,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  output logic        bus_we,
  output logic        cpu_rdy,
  output logic        dma_busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  page;
  logic [7:0]  idx;
  logic [7:0]  data;
  logic        odd;
  logic        trig;

  assign trig = cpu_we && (cpu_addr == DMA_REG);

  always_ff @(posedge clk_ph1) begin
    if (!rst) begin
      state <= S_IDLE;
      odd   <= 1'b0;
    end else begin
      state <= state_nxt;
      odd   <= ~odd;
    end
  end

  // Transfer registers; idx wraps within the page and never carries into page.
  always_ff @(posedge clk_ph1) begin
    if (!rst) begin
      page <= 8'h00;
      idx  <= 8'h00;
      data <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (trig) begin
            page <= cpu_dout;
            idx  <= 8'h00;
          end
        end
        S_READ:  data <= bus_din;
        S_WRITE: begin
          if (idx != 8'hFF) idx <= idx + 8'h01;
        end
        default: ;
      endcase
    end
  end

  // HALT leaves for READ only when the next cycle is even, so reads land on odd=0.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (trig) state_nxt = S_HALT;
      S_HALT:  if (!cpu_we) state_nxt = odd ? S_READ : S_ALIGN;
      S_ALIGN: state_nxt = S_READ;
      S_READ:  state_nxt = S_WRITE;
      S_WRITE: state_nxt = (idx == 8'hFF) ? S_IDLE : S_READ;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus_addr = cpu_addr;
    bus_dout = cpu_dout;
    bus_we   = cpu_we;
    cpu_rdy  = 1'b0;
    dma_busy = 1'b1;
    case (state)
      S_IDLE: begin
        cpu_rdy  = 1'b1;
        dma_busy = 1'b0;
      end
      S_HALT: ;
      S_ALIGN: bus_we = 1'b0;
      S_READ: begin
        bus_addr = {page, idx};
        bus_we   = 1'b0;
      end
      S_WRITE: begin
        bus_addr = OAM_PORT;
        bus_dout = data;
        bus_we   = 1'b1;
      end
      default: begin
        cpu_rdy  = 1'b1;
        dma_busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: IDLE pass-through vectors plus full
// transfers covering alignment, writes during HALT, page wrap and mid-transfer reset.
module tb_oam_dma_ctrl;

  logic        clk_ph1 = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] cpu_addr = 16'h0123;
  logic [7:0]  cpu_dout = 8'h00;
  logic        cpu_we = 1'b0;
  logic [7:0]  bus_din;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_we;
  logic        cpu_rdy;
  logic        dma_busy;

  localparam logic [15:0] OAM = 16'h2004;

  oam_dma_ctrl dut (
    .clk_ph1 (clk_ph1),
    .rst     (rst),
    .cpu_addr(cpu_addr),
    .cpu_dout(cpu_dout),
    .cpu_we  (cpu_we),
    .bus_din (bus_din),
    .bus_addr(bus_addr),
    .bus_dout(bus_dout),
    .bus_we  (bus_we),
    .cpu_rdy (cpu_rdy),
    .dma_busy(dma_busy)
  );

  always #5 clk_ph1 = ~clk_ph1;

  // Memory: byte at {p,i} = i + p - 2, so page 02 holds its index value.
  assign bus_din = 8'(bus_addr[7:0] + bus_addr[15:8] - 8'h02);

  // Expected cycle parity, cleared by reset and toggling each edge.
  logic tb_odd = 1'b0;
  always @(posedge clk_ph1) tb_odd <= (!rst) ? 1'b0 : ~tb_odd;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic we);
    @(negedge clk_ph1);
    cpu_addr = a;
    cpu_dout = d;
    cpu_we   = we;
    #1;
  endtask

  task automatic chk_mirror(input string nm);
    chk({nm, " bus_addr"}, {16'h0, bus_addr}, {16'h0, cpu_addr});
    chk({nm, " bus_dout"}, {24'h0, bus_dout}, {24'h0, cpu_dout});
    chk({nm, " bus_we"}, {31'h0, bus_we}, {31'h0, cpu_we});
  endtask

  task automatic do_reset();
    @(negedge clk_ph1);
    rst = 1'b0;
    cpu_addr = 16'h0123;
    cpu_dout = 8'h00;
    cpu_we = 1'b0;
    @(negedge clk_ph1);
    rst = 1'b1;
    #1;
  endtask

  // Runs one transfer. halt_odd: parity of the first HALT cycle; nwr: CPU write
  // cycles issued in HALT (first one to $4014 with 05); abort_idx >= 0 resets
  // the block during the READ of that index.
  task automatic xfer(input logic [7:0] pg, input logic halt_odd, input int nwr,
                      input int abort_idx, input string nm);
    int guard, stall, nrd, nwrs, bad_rd, bad_wr, bad_par, bad_busy;
    int dummies, bad_align, halt_wr, zero_acc, align_exp, late_wr, late_busy;
    logic [15:0] last_rd;
    logic [7:0]  exp_d;
    logic        done, aborted;
    guard = 0; stall = 0; nrd = 0; nwrs = 0; bad_rd = 0; bad_wr = 0; bad_par = 0;
    bad_busy = 0; dummies = 0; bad_align = 0; halt_wr = 0; zero_acc = 0;
    late_wr = 0; late_busy = 0; last_rd = 16'h0; done = 1'b0; aborted = 1'b0;
    align_exp = ((halt_odd ^ nwr[0]) == 1'b1) ? 0 : 1;

    do begin
      @(negedge clk_ph1);
      cpu_addr = 16'h0123; cpu_dout = 8'h00; cpu_we = 1'b0;
      guard++;
    end while (tb_odd == halt_odd && guard < 10);
    cpu_addr = 16'h4014; cpu_dout = pg; cpu_we = 1'b1;
    #1;
    chk({nm, " trigger rdy"}, {31'h0, cpu_rdy}, 32'h1);
    chk({nm, " trigger bus_we"}, {31'h0, bus_we}, 32'h1);

    for (int c = 0; c < 700 && !done && !aborted; c++) begin
      if (c < nwr) drive((c == 0) ? 16'h4014 : 16'h0400, (c == 0) ? 8'h05 : 8'h77, 1'b1);
      else drive(16'h0123, 8'h00, 1'b0);
      if (c == 0) begin
        chk({nm, " first halt rdy"}, {31'h0, cpu_rdy}, 32'h0);
        chk({nm, " first halt busy"}, {31'h0, dma_busy}, 32'h1);
      end
      if (dma_busy !== ~cpu_rdy) bad_busy++;
      if (bus_addr == 16'h0000) zero_acc++;
      if (cpu_rdy) begin
        done = 1'b1;
      end else begin
        stall++;
        if (c < nwr) begin
          if (bus_addr === cpu_addr && bus_we === 1'b1 && bus_dout === cpu_dout) halt_wr++;
        end else if (bus_we && bus_addr == OAM) begin
          exp_d = 8'(nwrs) + pg - 8'h02;
          if (bus_dout !== exp_d) bad_wr++;
          if (tb_odd !== 1'b1) bad_par++;
          nwrs++;
        end else if (bus_addr == cpu_addr) begin
          dummies++;
          if (bus_we !== 1'b0) bad_align++;
        end else begin
          if (bus_we !== 1'b0 || bus_addr !== {pg, 8'(nrd)}) bad_rd++;
          if (tb_odd !== 1'b0) bad_par++;
          last_rd = bus_addr;
          if (nrd == abort_idx) begin
            rst = 1'b0;
            aborted = 1'b1;
          end
          nrd++;
        end
      end
    end

    if (aborted) begin
      @(negedge clk_ph1);
      rst = 1'b1;
      cpu_addr = 16'h0300; cpu_dout = 8'h3C; cpu_we = 1'b0;
      #1;
      chk({nm, " post-reset rdy"}, {31'h0, cpu_rdy}, 32'h1);
      chk({nm, " post-reset busy"}, {31'h0, dma_busy}, 32'h0);
      chk_mirror({nm, " post-reset"});
      for (int c = 0; c < 600; c++) begin
        drive(16'h0123, 8'h00, 1'b0);
        if (bus_we && bus_addr == OAM) late_wr++;
        if (dma_busy || !cpu_rdy) late_busy++;
      end
      chk({nm, " writes after reset"}, late_wr, 0);
      chk({nm, " busy after reset"}, late_busy, 0);
      chk({nm, " reads before reset"}, nrd, abort_idx + 1);
      chk({nm, " read addr errors"}, bad_rd, 0);
    end else begin
      chk({nm, " end busy"}, {31'h0, dma_busy}, 32'h0);
      chk_mirror({nm, " end"});
      chk({nm, " stall cycles"}, stall, 513 + nwr + align_exp);
      chk({nm, " read count"}, nrd, 256);
      chk({nm, " write count"}, nwrs, 256);
      chk({nm, " read addr errors"}, bad_rd, 0);
      chk({nm, " write data errors"}, bad_wr, 0);
      chk({nm, " parity errors"}, bad_par, 0);
      chk({nm, " last read addr"}, {16'h0, last_rd}, {16'h0, pg, 8'hFF});
      chk({nm, " dummy cycles"}, dummies, 1 + align_exp);
      chk({nm, " align bus_we"}, bad_align, 0);
      chk({nm, " halt writes on bus"}, halt_wr, nwr);
    end
    chk({nm, " busy vs rdy"}, bad_busy, 0);
    chk({nm, " access to 0000"}, zero_acc, 0);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        we;
    logic [15:0] ea;
    logic [7:0]  ed;
    logic        ewe;
    logic        erdy;
    logic        ebusy;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{16'h2004, 8'hAA, 1'b1, 16'h2004, 8'hAA, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{16'h0300, 8'h11, 1'b0, 16'h0300, 8'h11, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{16'h4014, 8'h02, 1'b0, 16'h4014, 8'h02, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'h4015, 8'h5A, 1'b1, 16'h4015, 8'h5A, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{16'h4004, 8'hC3, 1'b1, 16'h4004, 8'hC3, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{16'hFFFC, 8'h00, 1'b0, 16'hFFFC, 8'h00, 1'b0, 1'b1, 1'b0};

    do_reset();
    chk("reset rdy", {31'h0, cpu_rdy}, 32'h1);
    chk("reset busy", {31'h0, dma_busy}, 32'h0);
    chk_mirror("reset");

    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].a, vecs[i].d, vecs[i].we);
      chk($sformatf("vec%0d bus_addr", i), {16'h0, bus_addr}, {16'h0, vecs[i].ea});
      chk($sformatf("vec%0d bus_dout", i), {24'h0, bus_dout}, {24'h0, vecs[i].ed});
      chk($sformatf("vec%0d bus_we", i), {31'h0, bus_we}, {31'h0, vecs[i].ewe});
      chk($sformatf("vec%0d rdy", i), {31'h0, cpu_rdy}, {31'h0, vecs[i].erdy});
      chk($sformatf("vec%0d busy", i), {31'h0, dma_busy}, {31'h0, vecs[i].ebusy});
    end
    drive(16'h0123, 8'h00, 1'b0);
    chk("idle after vectors busy", {31'h0, dma_busy}, 32'h0);

    xfer(8'h02, 1'b1, 0, -1, "basic");
    xfer(8'h02, 1'b0, 0, -1, "align");
    xfer(8'h02, 1'b1, 2, -1, "halt_wr");
    xfer(8'h02, 1'b0, 2, -1, "halt_wr_align");
    xfer(8'hFF, 1'b1, 0, -1, "wrap");
    xfer(8'h02, 1'b1, 0, 8'h40, "abort");
    xfer(8'h02, 1'b0, 0, -1, "after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
